// File: rtl/cd_spi_slave.sv
`timescale 1ns/1ps
// SPI mode-0 slave that turns a command byte plus data bytes into CSR read/write strobes.
// sclk/nss/sdi are oversampled on clk; strobes follow the synced completing sclk edge by 1 clk.
module cd_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       sclk,
  input  logic       nss,
  input  logic       sdi,
  output logic       sdo,
  output logic       sdo_en,
  output logic       int_flag_update,
  output logic [4:0] csr_address,
  output logic       csr_read,
  input  logic [7:0] csr_readdata,
  output logic       csr_write,
  output logic [7:0] csr_writedata
);

  typedef enum logic [1:0] {IDLE = 2'd0, CMD = 2'd1, WR = 2'd2, RD = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_sync, nss_sync, sdi_sync;
  logic                   sclk_d, nss_d;
  logic [SYNC_STAGES:0]   fill;
  logic [2:0]             bit_cnt;
  logic [7:0]             rx_shift, tx_shift;
  logic                   rd_d, wr_d, flag_d, byte_done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      nss_sync  <= '1;
      sdi_sync  <= '0;
      sclk_d    <= 1'b0;
      nss_d     <= 1'b1;
      fill      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      nss_sync  <= {nss_sync[SYNC_STAGES-2:0], nss};
      sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      sclk_d    <= sclk_sync[SYNC_STAGES-1];
      nss_d     <= nss_sync[SYNC_STAGES-1];
      fill      <= {fill[SYNC_STAGES-1:0], 1'b1};
    end
  end

  logic sclk_s, nss_s, sdi_s, sync_ready;
  logic sclk_rise, sclk_fall, nss_fall, nss_rise, active;
  logic [7:0] rx_byte;

  assign sclk_s     = sclk_sync[SYNC_STAGES-1];
  assign nss_s      = nss_sync[SYNC_STAGES-1];
  assign sdi_s      = sdi_sync[SYNC_STAGES-1];
  // A falling nss only counts once the pipeline holds real samples, so an nss
  // already low at reset release does not look like a fresh select.
  assign sync_ready = fill[SYNC_STAGES];
  assign sclk_rise  = sclk_s & ~sclk_d;
  assign sclk_fall  = ~sclk_s & sclk_d;
  assign nss_fall   = sync_ready & nss_d & ~nss_s;
  assign nss_rise   = ~nss_d & nss_s;
  assign active     = (state_q != IDLE) & ~nss_s;
  assign rx_byte    = {rx_shift[6:0], sdi_s};

  always_comb begin
    state_d   = state_q;
    rd_d      = 1'b0;
    wr_d      = 1'b0;
    flag_d    = 1'b0;
    byte_done = active & sclk_rise & (bit_cnt == 3'd7);
    if (nss_rise) begin
      state_d = IDLE;
    end else if (nss_fall) begin
      state_d = CMD;
      flag_d  = 1'b1;
    end else if (byte_done) begin
      case (state_q)
        CMD: begin
          state_d = rx_byte[7] ? WR : RD;
          rd_d    = ~rx_byte[7];
        end
        WR:      wr_d = 1'b1;
        RD:      rd_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt         <= '0;
      rx_shift        <= '0;
      tx_shift        <= '0;
      csr_address     <= '0;
      csr_writedata   <= '0;
      csr_read        <= 1'b0;
      csr_write       <= 1'b0;
      int_flag_update <= 1'b0;
    end else begin
      csr_read        <= rd_d;
      csr_write       <= wr_d;
      int_flag_update <= flag_d;
      if (nss_fall) begin
        bit_cnt  <= '0;
        rx_shift <= '0;
      end else if (active && sclk_rise) begin
        bit_cnt  <= bit_cnt + 3'd1;
        rx_shift <= rx_byte;
      end
      if (byte_done && state_q == CMD) csr_address   <= rx_byte[4:0];
      if (byte_done && state_q == WR)  csr_writedata <= rx_byte;
      // The falling edge right after a completed byte is skipped so the freshly
      // loaded MSB stays on sdo for the master's next rising edge.
      if (csr_read)
        tx_shift <= csr_readdata;
      else if (state_q == RD && active && sclk_fall && bit_cnt != 3'd0)
        tx_shift <= {tx_shift[6:0], 1'b0};
    end
  end

  assign sdo    = (state_q == RD) ? tx_shift[7] : 1'b0;
  assign sdo_en = ~nss_s;

endmodule

// File: tb/tb_cd_spi_slave.sv
`timescale 1ns/1ps
// Bench for cd_spi_slave: a bit-banged SPI master, a CSR register file, and a
// transaction-level model of the strobes and MISO bytes each transfer must produce.
module tb_cd_spi_slave;

  logic       clk, reset_n, sclk, nss, sdi;
  logic       sdo, sdo_en, int_flag_update, csr_read, csr_write;
  logic [4:0] csr_address;
  logic [7:0] csr_readdata, csr_writedata;

  cd_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset_n(reset_n), .sclk(sclk), .nss(nss), .sdi(sdi),
    .sdo(sdo), .sdo_en(sdo_en), .int_flag_update(int_flag_update),
    .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
    .csr_write(csr_write), .csr_writedata(csr_writedata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] a;
    logic [7:0] d;
    int         due;
  } ev_t;

  int   n_cmp = 0, n_bad = 0;
  int   cyc = 0, ph = 3;
  int   n_wr = 0, n_rd = 0, n_flag = 0, exp_flag = 0;
  logic [4:0] last_wr_a;
  logic [7:0] last_wr_d, miso_last;
  logic [7:0] exp_mem [32];
  logic [7:0] csr_mem [32];
  logic       mem_init = 1'b0;
  logic [7:0] txb [4];
  ev_t        wr_q[$], rd_q[$];

  function automatic logic [7:0] init_val(input int i);
    return 8'(i * 29 + 14);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // CSR block stand-in: combinational read data, writes land on the strobe.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 32; i++) csr_mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else if (csr_write) begin
      csr_mem[csr_address] <= csr_writedata;
    end
  end
  assign csr_readdata = csr_mem[csr_address];

  always @(negedge clk) begin
    ev_t e;
    if (reset_n) begin
      check("rd_wr_exclusive", {31'd0, csr_read & csr_write}, 0);
      if (int_flag_update) n_flag++;
      if (csr_write) begin
        n_wr++;
        last_wr_a = csr_address;
        last_wr_d = csr_writedata;
        if (wr_q.size() == 0) check("unexpected_write", {31'd0, csr_write}, 0);
        else begin
          e = wr_q.pop_front();
          check("wr_addr", {27'd0, csr_address}, {27'd0, e.a});
          check("wr_data", {24'd0, csr_writedata}, {24'd0, e.d});
          check("wr_latency", cyc, e.due);
        end
      end
      if (csr_read) begin
        n_rd++;
        if (rd_q.size() == 0) check("unexpected_read", {31'd0, csr_read}, 0);
        else begin
          e = rd_q.pop_front();
          check("rd_addr", {27'd0, csr_address}, {27'd0, e.a});
          check("rd_latency", cyc, e.due);
        end
      end
    end
  end

  task automatic sclk_edge();
    repeat (4) @(posedge clk);
    #(ph);
  endtask

  // kind: 0 no strobe expected, 1 read, 2 write; cut raises nss with the 8th rising edge.
  task automatic send_byte(input logic [7:0] v, input int nbits, input int kind,
                           input logic [4:0] a, input bit cut, output logic [7:0] mb);
    ev_t e;
    mb = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      sdi = v[7-i];
      sclk_edge();
      sclk = 1'b1;
      mb = {mb[6:0], sdo};
      if (i == 7) begin
        e.a = a; e.d = v; e.due = cyc + 3;
        if (cut) nss = 1'b1;
        else if (kind == 1) rd_q.push_back(e);
        else if (kind == 2) wr_q.push_back(e);
      end
      sclk_edge();
      sclk = 1'b0;
    end
  endtask

  task automatic run_txn(input int nb, input int part_bits, input bit cut_last);
    logic [4:0] a;
    logic       w, cut;
    logic [7:0] mb;
    int         kind;
    a = txb[0][4:0];
    w = txb[0][7];
    @(posedge clk); #(ph);
    nss = 1'b0;
    exp_flag++;
    for (int b = 0; b < nb; b++) begin
      kind = (b == 0) ? (w ? 0 : 1) : (w ? 2 : 1);
      cut  = cut_last && (b == nb - 1);
      send_byte(txb[b], 8, kind, a, cut, mb);
      if (kind == 2 && !cut) exp_mem[a] = txb[b];
      check("miso_byte", {24'd0, mb}, {24'd0, (b > 0 && !w) ? exp_mem[a] : 8'h00});
      miso_last = mb;
    end
    if (part_bits > 0) send_byte(txb[nb], part_bits, 0, a, 1'b0, mb);
    if (!cut_last) check("sdo_en_selected", {31'd0, sdo_en}, 1);
    sclk_edge();
    nss = 1'b1;
    sdi = 1'b0;
    sclk_edge();
    sclk_edge();
    check("sdo_en_deselected", {31'd0, sdo_en}, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_csr_address"}, {27'd0, csr_address}, 0);
    check({tag, "_csr_writedata"}, {24'd0, csr_writedata}, 0);
    check({tag, "_csr_read"}, {31'd0, csr_read}, 0);
    check({tag, "_csr_write"}, {31'd0, csr_write}, 0);
    check({tag, "_int_flag"}, {31'd0, int_flag_update}, 0);
    check({tag, "_sdo"}, {31'd0, sdo}, 0);
    check({tag, "_sdo_en"}, {31'd0, sdo_en}, 0);
  endtask

  initial begin
    int         w0, r0, f0, nb;
    logic [7:0] mb;
    for (int i = 0; i < 32; i++) exp_mem[i] = init_val(i);
    reset_n = 1'b0; sclk = 1'b0; nss = 1'b1; sdi = 1'b0;
    repeat (3) @(posedge clk);
    #2 check_idle("reset");
    @(posedge clk); #(ph);
    reset_n = 1'b1;
    repeat (4) @(posedge clk);

    // Single write: cmd 0x82 -> address 2, data 0x5A.
    w0 = n_wr; f0 = n_flag; ph = 2;
    txb[0] = 8'h82; txb[1] = 8'h5A;
    run_txn(2, 0, 1'b0);
    check("wr1_count", n_wr - w0, 1);
    check("wr1_addr", {27'd0, last_wr_a}, 32'h02);
    check("wr1_data", {24'd0, last_wr_d}, 32'h5A);
    check("wr1_flag", n_flag - f0, 1);

    // Read address 0 (0x0E): second MISO byte carries it; data read + prefetch.
    r0 = n_rd; ph = 7;
    txb[0] = 8'h00; txb[1] = 8'h00;
    run_txn(2, 0, 1'b0);
    check("rd1_miso", {24'd0, miso_last}, 32'h0E);
    check("rd1_reads", n_rd - r0, 2);

    // Burst write streams to one address; bits 6:5 of the command are ignored.
    w0 = n_wr; ph = 4;
    txb[0] = 8'h95; txb[1] = 8'h11; txb[2] = 8'h22; txb[3] = 8'h33;
    run_txn(4, 0, 1'b0);
    check("burst_count", n_wr - w0, 3);
    check("burst_addr", {27'd0, last_wr_a}, 32'h15);
    check("burst_last", {24'd0, last_wr_d}, 32'h33);

    // Deselect after 5 bits of a data byte, then a normal write.
    w0 = n_wr; ph = 1;
    txb[0] = 8'h81; txb[1] = 8'hAB;
    run_txn(1, 5, 1'b0);
    check("abort_count", n_wr - w0, 0);
    txb[0] = 8'h83; txb[1] = 8'h77;
    run_txn(2, 0, 1'b0);
    check("after_abort_count", n_wr - w0, 1);
    check("after_abort_addr", {27'd0, last_wr_a}, 32'h03);
    check("after_abort_data", {24'd0, last_wr_d}, 32'h77);

    // nss rising together with the completing edge wins: no write.
    w0 = n_wr; ph = 6;
    txb[0] = 8'h84; txb[1] = 8'hC3;
    run_txn(2, 0, 1'b1);
    check("cut_count", n_wr - w0, 0);

    // Reset in the middle of a read; nss stays low across release.
    r0 = n_rd; w0 = n_wr; f0 = n_flag; ph = 5;
    @(posedge clk); #(ph);
    nss = 1'b0;
    exp_flag++;
    send_byte(8'h01, 8, 1, 5'h01, 1'b0, mb);
    send_byte(8'hFF, 4, 0, 5'h01, 1'b0, mb);
    check("rst_mid_sdo_en", {31'd0, sdo_en}, 1);
    #2 reset_n = 1'b0;
    #1 check_idle("rst_mid");
    repeat (3) @(posedge clk); #(ph);
    reset_n = 1'b1;
    send_byte(8'h80, 8, 0, 5'h00, 1'b0, mb);
    send_byte(8'h55, 8, 0, 5'h00, 1'b0, mb);
    check("rst_reads", n_rd - r0, 1);
    check("rst_writes", n_wr - w0, 0);
    check("rst_flags", n_flag - f0, 1);
    sclk_edge();
    nss = 1'b1;
    sclk_edge();
    sclk_edge();
    w0 = n_wr;
    txb[0] = 8'h9F; txb[1] = 8'h5C;
    run_txn(2, 0, 1'b0);
    check("post_rst_count", n_wr - w0, 1);
    check("post_rst_addr", {27'd0, last_wr_a}, 32'h1F);
    check("post_rst_data", {24'd0, last_wr_d}, 32'h5C);

    // Random read/write transfers at sclk = clk/8 with random clk phase.
    for (int t = 0; t < 200; t++) begin
      ph = $urandom_range(1, 8);
      nb = $urandom_range(2, 3);
      for (int i = 0; i < 4; i++) txb[i] = 8'($urandom);
      run_txn(nb, 0, 1'b0);
    end

    repeat (10) @(posedge clk);
    check("pending_writes", wr_q.size(), 0);
    check("pending_reads", rd_q.size(), 0);
    check("flag_count", n_flag, exp_flag);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
